// File: rtl/bu_pipe.sv
// Four-stage modular butterfly (CT forward / GS inverse) with valid/ready flow control.
// One global enable stalls every stage, bubbles included, whenever the output is held.
module bu_pipe #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_tf,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic             out_err
);
  localparam int STAGES = 4;
  localparam logic [WIDTH-1:0]   QW      = WIDTH'(Q);
  localparam logic [2*WIDTH:0]   POW2    = {1'b1, {(2*WIDTH){1'b0}}};
  localparam logic [2*WIDTH:0]   MU_FULL = POW2 / (2*WIDTH+1)'(Q);
  localparam logic [WIDTH:0]     MU      = (WIDTH+1)'(MU_FULL);

  typedef struct packed {
    logic             mode;
    logic             err;
    logic [TAG_W-1:0] tag;
  } side_t;

  // Out-of-range inputs are below 2Q, so one subtraction keeps every stage canonical.
  function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] v);
    return (v >= QW) ? v - QW : v;
  endfunction

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, QW}) s = s - {1'b0, QW};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? a - b : a + (QW - b);
  endfunction

  // Barrett: the quotient estimate is short by at most 2, so r < 3Q fits WIDTH+2 bits.
  function automatic logic [WIDTH-1:0] barrett(input logic [2*WIDTH-1:0] x);
    logic [WIDTH:0]     q1;
    logic [2*WIDTH+1:0] q2;
    logic [WIDTH:0]     q3;
    logic [2*WIDTH+1:0] qq;
    logic [WIDTH+1:0]   r;
    q1 = x[2*WIDTH-1:WIDTH-1];
    q2 = (2*WIDTH+2)'(q1) * (2*WIDTH+2)'(MU);
    q3 = (WIDTH+1)'(q2 >> (WIDTH+1));
    qq = (2*WIDTH+2)'(q3) * (2*WIDTH+2)'(QW);
    r  = (WIDTH+2)'((2*WIDTH+2)'(x) - qq);
    if (r >= {2'b00, QW}) r = r - {2'b00, QW};
    if (r >= {2'b00, QW}) r = r - {2'b00, QW};
    return r[WIDTH-1:0];
  endfunction

  logic [STAGES:1]          vld_pipe_q;
  side_t [STAGES:1]         sb_q;
  logic [WIDTH-1:0]         a1_q, m1_q, tf1_q, a2_q, a3_q, p3_q, outa_q, outb_q;
  logic [2*WIDTH-1:0]       prod2_q;

  side_t                    sb_d;
  logic [WIDTH-1:0]         xc, yc, a1_d, m1_d, p3_d, outa_d, outb_d;
  logic [2*WIDTH-1:0]       prod2_d;
  logic                     en;

  assign en       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready = en;

  always_comb begin
    xc       = canon(in_x);
    yc       = canon(in_y);
    sb_d     = '0;
    sb_d.mode = in_mode;
    sb_d.err  = (in_x >= QW) || (in_y >= QW) || (in_tf >= QW);
    sb_d.tag  = in_tag;
    a1_d     = in_mode ? add_mod(xc, yc) : xc;
    m1_d     = in_mode ? sub_mod(xc, yc) : yc;
    prod2_d  = (2*WIDTH)'(m1_q) * (2*WIDTH)'(tf1_q);
    p3_d     = barrett(prod2_q);
    outa_d   = sb_q[3].mode ? a3_q : add_mod(a3_q, p3_q);
    outb_d   = sb_q[3].mode ? p3_q : sub_mod(a3_q, p3_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      sb_q       <= '0;
      a1_q       <= '0;
      m1_q       <= '0;
      tf1_q      <= '0;
      prod2_q    <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      p3_q       <= '0;
      outa_q     <= '0;
      outb_q     <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      sb_q       <= {sb_q[STAGES-1:1], sb_d};
      a1_q       <= a1_d;
      m1_q       <= m1_d;
      tf1_q      <= canon(in_tf);
      prod2_q    <= prod2_d;
      a2_q       <= a1_q;
      a3_q       <= a2_q;
      p3_q       <= p3_d;
      outa_q     <= outa_d;
      outb_q     <= outb_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_a     = outa_q;
  assign out_b     = outb_q;
  assign out_tag   = sb_q[STAGES].tag;
  assign out_mode  = sb_q[STAGES].mode;
  assign out_err   = sb_q[STAGES].err;
endmodule

// File: tb/tb_bu_pipe.sv
// Randomised bench for bu_pipe: directed vectors, a back-pressured mixed stream
// against a mod-Q arithmetic model, error flag isolation and mid-flight reset.
module tb_bu_pipe;
  localparam int W  = 23;
  localparam int TW = 8;
  localparam longint QL = 8380417;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_mode;
  logic [W-1:0]  in_x, in_y, in_tf;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_a, out_b;
  logic [TW-1:0] out_tag;
  logic          out_mode, out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  bu_pipe #(.WIDTH(W), .Q(8380417), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_tf(in_tf), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
    .out_mode(out_mode), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference butterfly straight from the modular definitions.
  function automatic void model(input bit mode, input longint x, input longint y,
                                input longint tf, output longint a, output longint b);
    longint p;
    if (!mode) begin
      p = (y * tf) % QL;
      a = (x + p) % QL;
      b = (x - p + QL) % QL;
    end else begin
      a = (x + y) % QL;
      b = (((x - y + QL) % QL) * tf) % QL;
    end
  endfunction

  function automatic logic [W-1:0] rnd_op();
    int k;
    k = $urandom_range(7, 0);
    if (k == 0) return W'(QL - 1);
    if (k == 1) return '0;
    return W'($urandom_range(32'(QL - 1), 0));
  endfunction

  // Drives one transaction into an idle pipe and waits for its result.
  task automatic do_txn(input bit mode, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] tf, input logic [TW-1:0] tag,
                        output int lat, output logic [W-1:0] a, output logic [W-1:0] b,
                        output logic err, output logic [TW-1:0] tag_o);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = mode; in_x = x; in_y = y; in_tf = tf; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (out_valid) begin lat = c; break; end
      @(negedge clk);
    end
    a = out_a; b = out_b; err = out_err; tag_o = out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_tf = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_err !== 1'b0 || out_mode !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b err=%b mode=%b, want 0 0 0", out_valid, out_err, out_mode);
    end
    n_cmp++;
    if (out_a !== '0 || out_b !== '0 || out_tag !== '0) begin
      n_fail++; $display("FAIL reset_data: a=%0d b=%0d tag=%0d, want 0 0 0", out_a, out_b, out_tag);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    bit          md [7]  = '{0, 0, 0, 1, 1, 0, 1};
    int          xs [7]  = '{1, 0, 8380416, 5, 3, 0, 0};
    int          ys [7]  = '{2, 8380416, 1, 3, 5, 0, 0};
    int          ts [7]  = '{3, 8380416, 1, 2, 1, 0, 0};
    int          ea [7]  = '{7, 1, 0, 8, 8, 0, 0};
    int          eb [7]  = '{8380412, 8380416, 8380415, 4, 8380415, 0, 0};
    int          lat;
    logic [W-1:0] a, b;
    logic        err;
    logic [TW-1:0] tg;
    for (int i = 0; i < 7; i++) begin
      do_txn(md[i], W'(xs[i]), W'(ys[i]), W'(ts[i]), TW'(i + 200), lat, a, b, err, tg);
      n_cmp++;
      if (lat != 4) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d cycles want 4", i, lat);
      end
      n_cmp++;
      if (a !== W'(ea[i]) || b !== W'(eb[i]) || err !== 1'b0 || tg !== TW'(i + 200)) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: a=%0d b=%0d err=%b tag=%0d want a=%0d b=%0d err=0 tag=%0d",
                 i, a, b, err, tg, ea[i], eb[i], i + 200);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit           md [100];
    logic [W-1:0] xs [100], ys [100], ts [100];
    longint       ea, eb;
    int           sent = 0, rcv = 0;
    bit           held = 0;
    logic [W-1:0] ha, hb;
    logic [TW-1:0] ht;
    for (int i = 0; i < 100; i++) begin
      md[i] = 1'($urandom_range(1, 0));
      xs[i] = rnd_op(); ys[i] = rnd_op(); ts[i] = rnd_op();
    end
    for (int cyc = 0; cyc < 3000 && rcv < 100; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(3, 0) != 0);
      if (sent < 100 && $urandom_range(7, 0) != 0) begin
        in_valid = 1'b1; in_mode = md[sent]; in_x = xs[sent]; in_y = ys[sent];
        in_tf = ts[sent]; in_tag = TW'(sent);
      end else begin
        in_valid = 1'b0;
        in_x = rnd_op(); in_tag = 8'hEE;
      end
      #1;
      n_cmp++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL stream_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_a !== ha || out_b !== hb || out_tag !== ht) begin
          n_fail++;
          $display("FAIL stream_hold: valid=%b a=%0d b=%0d tag=%0d want 1 %0d %0d %0d",
                   out_valid, out_a, out_b, out_tag, ha, hb, ht);
        end
      end
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          model(md[rcv], longint'(xs[rcv]), longint'(ys[rcv]), longint'(ts[rcv]), ea, eb);
          n_cmp++;
          if (out_tag !== TW'(rcv) || out_mode !== md[rcv] || out_err !== 1'b0 ||
              out_a !== W'(ea) || out_b !== W'(eb)) begin
            n_fail++;
            $display("FAIL stream_result[%0d]: tag=%0d mode=%b err=%b a=%0d b=%0d want tag=%0d mode=%b err=0 a=%0d b=%0d",
                     rcv, out_tag, out_mode, out_err, out_a, out_b, rcv, md[rcv], ea, eb);
          end
          rcv++;
        end else begin
          held = 1; ha = out_a; hb = out_b; ht = out_tag;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (rcv != 100 || sent != 100) begin
      n_fail++; $display("FAIL stream_count: sent=%0d received=%0d want 100 100", sent, rcv);
    end
  endtask

  task automatic test_err();
    logic [W-1:0] ys [3] = '{23'd5, 23'd8380417, 23'd7};
    bit           ee [3] = '{0, 1, 0};
    int           got = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = 1'(i); in_x = 23'd9; in_y = ys[i]; in_tf = 23'd11;
      in_tag = TW'(10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      #1;
      if (out_valid) begin
        n_cmp++;
        if (out_tag !== TW'(10 + got) || out_err !== ee[got] ||
            out_a >= W'(QL) || out_b >= W'(QL)) begin
          n_fail++;
          $display("FAIL err_flag[%0d]: tag=%0d err=%b a=%0d b=%0d want tag=%0d err=%b a,b<Q",
                   got, out_tag, out_err, out_a, out_b, 10 + got, ee[got]);
        end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got != 3) begin
      n_fail++; $display("FAIL err_count: got %0d results want 3", got);
    end
  endtask

  task automatic test_reset_midflight();
    int           lat;
    logic [W-1:0] a, b;
    logic         err;
    logic [TW-1:0] tg;
    int           seen = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_x = 23'd1; in_y = 23'd1; in_tf = 23'd1;
      in_tag = TW'(50 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midflight_flush: %0d valid cycles after reset, want 0", seen);
    end
    do_txn(1'b1, 23'd5, 23'd3, 23'd2, 8'd77, lat, a, b, err, tg);
    n_cmp++;
    if (lat != 4 || a !== 23'd8 || b !== 23'd4 || tg !== 8'd77) begin
      n_fail++;
      $display("FAIL midflight_next: lat=%0d a=%0d b=%0d tag=%0d want 4 8 4 77", lat, a, b, tg);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_err();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
